udma_l2_port_arbiter: RTL and testbench

Merges the uDMA subsystem's L2 read-only and write-only memory channels onto a single TCDM-style L2 master port. It is used in SoCs that expose only one L2 port to the IO domain. It arbitrates between the two channels, holds a pending request stable until the L2 grants it, and tracks outstanding transactions so each in-order L2 response returns to the channel that issued it. It sits between the uDMA subsystem's L2 ports and the SoC interconnect.

---
 rtl/udma_l2_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_udma_l2_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_l2_port_arbiter.sv
// udma_l2_port_arbiter
//
// Merges the uDMA read-only (RO) and write-only (WO) L2 channels onto one
// TCDM-style L2 master port. Request, grant and response paths are purely
// combinational. A small ID FIFO remembers which channel issued each granted
// transaction, so that in-order L2 responses are steered back to their owner.
//
// Configuration macro:
//   UDMA_L2_ARB_WRITE_PRIO_EN  defined   -> WO has fixed priority over RO
//                              undefined -> round-robin between RO and WO
//
// Ports:
//   sys_clk_i, sys_rst_i        clock, asynchronous active-high reset
//   ro_req_i/ro_gnt_o/ro_addr_i/ro_be_i/ro_rvalid_o/ro_rdata_o
//                               read channel (request side and response side)
//   wo_req_i/wo_gnt_o/wo_addr_i/wo_wdata_i/wo_be_i/wo_rvalid_o
//                               write channel (request side and acknowledge)
//   L2_req_o/L2_gnt_i/L2_wen_o/L2_addr_o/L2_be_o/L2_wdata_o/L2_rvalid_i/L2_rdata_i
//                               merged L2 master port (L2_wen_o: 1 = read, 0 = write)
//   outstanding_o               number of granted but unanswered transactions
//   err_o                       sticky: an L2 response arrived with nothing outstanding

module udma_l2_port_arbiter #(
   parameter int unsigned L2_DATA_WIDTH   = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                     sys_clk_i,
   input  logic                                     sys_rst_i,

   input  logic                                     ro_req_i,
   output logic                                     ro_gnt_o,
   input  logic [31:0]                              ro_addr_i,
   input  logic [L2_DATA_WIDTH/8-1:0]               ro_be_i,
   output logic                                     ro_rvalid_o,
   output logic [L2_DATA_WIDTH-1:0]                 ro_rdata_o,

   input  logic                                     wo_req_i,
   output logic                                     wo_gnt_o,
   input  logic [31:0]                              wo_addr_i,
   input  logic [L2_DATA_WIDTH-1:0]                 wo_wdata_i,
   input  logic [L2_DATA_WIDTH/8-1:0]               wo_be_i,
   output logic                                     wo_rvalid_o,

   output logic                                     L2_req_o,
   input  logic                                     L2_gnt_i,
   output logic                                     L2_wen_o,
   output logic [31:0]                              L2_addr_o,
   output logic [L2_DATA_WIDTH/8-1:0]               L2_be_o,
   output logic [L2_DATA_WIDTH-1:0]                 L2_wdata_o,
   input  logic                                     L2_rvalid_i,
   input  logic [L2_DATA_WIDTH-1:0]                 L2_rdata_i,

   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
   output logic                                     err_o
);

   localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic {
      ChRo = 1'b0,
      ChWo = 1'b1
   } ch_e;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   ch_e                        sel_q, sel_d;
   logic                       locked_q, locked_d;
   logic [CntW-1:0]            count_q, count_d;
   logic [PtrW-1:0]            wptr_q, wptr_d;
   logic [PtrW-1:0]            rptr_q, rptr_d;
   logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;   // 1 = WO issued that slot
   logic                       err_q, err_d;
`ifndef UDMA_L2_ARB_WRITE_PRIO_EN
   ch_e                        rr_q, rr_d;     // preferred channel on a tie
`endif

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   ch_e  arb_sel;
   ch_e  sel;
   logic full;
   logic l2_req;
   logic push;
   logic pop;
   logic head_is_wo;
   logic empty_rsp;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(MAX_OUTSTANDING - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   always_comb begin
      arb_sel = ChRo;
`ifdef UDMA_L2_ARB_WRITE_PRIO_EN
      if (wo_req_i) begin
         arb_sel = ChWo;
      end
`else
      if (ro_req_i && wo_req_i) begin
         arb_sel = rr_q;
      end else if (wo_req_i) begin
         arb_sel = ChWo;
      end
`endif
   end

   // While a request waits for its grant the selection is frozen so the L2
   // sees stable address/data.
   assign sel  = locked_q ? sel_q : arb_sel;
   assign full = (count_q == CntW'(MAX_OUTSTANDING));

   // Gating with reset keeps the request low while reset is held even when a
   // channel still drives its request.
   assign l2_req = (ro_req_i | wo_req_i) & ~full & ~sys_rst_i;

   assign push       = l2_req & L2_gnt_i;
   assign pop        = L2_rvalid_i & (count_q != '0);
   assign empty_rsp  = L2_rvalid_i & (count_q == '0);
   assign head_is_wo = ids_q[rptr_q];

   assign L2_req_o   = l2_req;
   assign L2_wen_o   = (sel == ChRo);
   assign L2_addr_o  = (sel == ChWo) ? wo_addr_i  : ro_addr_i;
   assign L2_be_o    = (sel == ChWo) ? wo_be_i    : ro_be_i;
   assign L2_wdata_o = (sel == ChWo) ? wo_wdata_i : '0;

   assign ro_gnt_o = L2_gnt_i & l2_req & (sel == ChRo);
   assign wo_gnt_o = L2_gnt_i & l2_req & (sel == ChWo);

   // A response with nothing outstanding (including late responses to
   // transactions lost across a reset) is never forwarded.
   assign ro_rvalid_o = pop & ~head_is_wo;
   assign wo_rvalid_o = pop & head_is_wo;
   assign ro_rdata_o  = L2_rdata_i;

   assign outstanding_o = count_q;
   assign err_o         = err_q;

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin
      sel_d    = sel;
      locked_d = l2_req & ~L2_gnt_i;
      count_d  = count_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      ids_d    = ids_q;
      err_d    = err_q | empty_rsp;

      if (push) begin
         ids_d[wptr_q] = (sel == ChWo);
         wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
         rptr_d = ptr_inc(rptr_q);
      end

      // Simultaneous push and pop leave the count unchanged.
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

`ifndef UDMA_L2_ARB_WRITE_PRIO_EN
   // After every grant the other channel becomes preferred.
   always_comb begin
      rr_d = rr_q;
      if (push) begin
         rr_d = (sel == ChRo) ? ChWo : ChRo;
      end
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         rr_q <= ChRo;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         sel_q    <= ChRo;
         locked_q <= 1'b0;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         ids_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         locked_q <= locked_d;
         count_q  <= count_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ids_q    <= ids_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_udma_l2_port_arbiter.sv
// Directed bench for udma_l2_port_arbiter (MAX_OUTSTANDING = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_udma_l2_port_arbiter;

   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          ro_req, ro_gnt, ro_rvalid;
   logic [31:0]   ro_addr;
   logic [3:0]    ro_be;
   logic [DW-1:0] ro_rdata;
   logic          wo_req, wo_gnt, wo_rvalid;
   logic [31:0]   wo_addr;
   logic [DW-1:0] wo_wdata;
   logic [3:0]    wo_be;
   logic          l2_req, l2_gnt, l2_wen, l2_rvalid;
   logic [31:0]   l2_addr;
   logic [3:0]    l2_be;
   logic [DW-1:0] l2_wdata, l2_rdata;
   logic [2:0]    outstanding;
   logic          err;

   int compared;
   int mismatched;

   // Expected grant owner (1 = WO) for a continuous RO+WO request stream.
   logic exp_wo_seq [4];

   udma_l2_port_arbiter #(
      .L2_DATA_WIDTH   (DW),
      .MAX_OUTSTANDING (4)
   ) dut (
      .sys_clk_i     (clk),
      .sys_rst_i     (rst),
      .ro_req_i      (ro_req),
      .ro_gnt_o      (ro_gnt),
      .ro_addr_i     (ro_addr),
      .ro_be_i       (ro_be),
      .ro_rvalid_o   (ro_rvalid),
      .ro_rdata_o    (ro_rdata),
      .wo_req_i      (wo_req),
      .wo_gnt_o      (wo_gnt),
      .wo_addr_i     (wo_addr),
      .wo_wdata_i    (wo_wdata),
      .wo_be_i       (wo_be),
      .wo_rvalid_o   (wo_rvalid),
      .L2_req_o      (l2_req),
      .L2_gnt_i      (l2_gnt),
      .L2_wen_o      (l2_wen),
      .L2_addr_o     (l2_addr),
      .L2_be_o       (l2_be),
      .L2_wdata_o    (l2_wdata),
      .L2_rvalid_i   (l2_rvalid),
      .L2_rdata_i    (l2_rdata),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ro_req = 0; ro_addr = '0; ro_be = '0;
      wo_req = 0; wo_addr = '0; wo_wdata = '0; wo_be = '0;
      l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst = 1;
      step();
      rst = 0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      #1;
      compared++; if (outstanding !== 3'd0) begin mismatched++;
         $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
      compared++; if (l2_req !== 1'b0) begin mismatched++;
         $display("FAIL reset_l2_req: got %b want 0", l2_req); end
      compared++; if (err !== 1'b0) begin mismatched++;
         $display("FAIL reset_err: got %b want 0", err); end
      compared++; if ({ro_gnt, wo_gnt, ro_rvalid, wo_rvalid} !== 4'b0) begin mismatched++;
         $display("FAIL reset_handshakes: got %b want 0000",
                  {ro_gnt, wo_gnt, ro_rvalid, wo_rvalid}); end
      step();
      rst = 0;
   endtask

   task automatic test_single_read();
      do_reset();
      ro_req = 1; ro_addr = 32'h1C00_0000; ro_be = 4'hF; l2_gnt = 1;
      #1;
      compared++; if ({l2_req, l2_wen, ro_gnt, wo_gnt} !== 4'b1110) begin mismatched++;
         $display("FAIL rd_req_wen_gnt: got %b want 1110", {l2_req, l2_wen, ro_gnt, wo_gnt}); end
      compared++; if (l2_addr !== 32'h1C00_0000) begin mismatched++;
         $display("FAIL rd_addr: got %h want 1c000000", l2_addr); end
      compared++; if (l2_wdata !== 32'h0) begin mismatched++;
         $display("FAIL rd_wdata: got %h want 0", l2_wdata); end
      step();
      ro_req = 0; l2_gnt = 0; l2_rvalid = 1; l2_rdata = 32'hDEAD_BEEF;
      #1;
      compared++; if (outstanding !== 3'd1) begin mismatched++;
         $display("FAIL rd_outstanding: got %0d want 1", outstanding); end
      compared++; if ({ro_gnt, ro_rvalid, wo_rvalid} !== 3'b010) begin mismatched++;
         $display("FAIL rd_rvalid: got %b want 010", {ro_gnt, ro_rvalid, wo_rvalid}); end
      compared++; if (ro_rdata !== 32'hDEAD_BEEF) begin mismatched++;
         $display("FAIL rd_rdata: got %h want deadbeef", ro_rdata); end
      step();
      l2_rvalid = 0;
      #1;
      compared++; if ({outstanding, err} !== 4'b0000) begin mismatched++;
         $display("FAIL rd_drain: got cnt=%0d err=%b want 0 0", outstanding, err); end
   endtask

   // Continuous RO+WO requests: checks the grant order, the full condition
   // and in-order response routing.
   task automatic test_arbitration_and_full();
      do_reset();
      ro_req = 1; ro_addr = 32'h100; ro_be = 4'h3;
      wo_req = 1; wo_addr = 32'h200; wo_wdata = 32'h55AA; wo_be = 4'hC;
      l2_gnt = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         compared++;
         if ({ro_gnt, wo_gnt} !== {~exp_wo_seq[i], exp_wo_seq[i]}) begin mismatched++;
            $display("FAIL arb_grant_%0d: got ro=%b wo=%b want wo=%b",
                     i, ro_gnt, wo_gnt, exp_wo_seq[i]); end
         step();
      end
      #1;
      compared++; if (outstanding !== 3'd4) begin mismatched++;
         $display("FAIL full_count: got %0d want 4", outstanding); end
      compared++; if ({l2_req, ro_gnt, wo_gnt} !== 3'b000) begin mismatched++;
         $display("FAIL full_req: got %b want 000", {l2_req, ro_gnt, wo_gnt}); end
      l2_gnt = 0; l2_rvalid = 1; l2_rdata = 32'h11;
      #1;
      compared++;
      if ({ro_rvalid, wo_rvalid} !== {~exp_wo_seq[0], exp_wo_seq[0]}) begin mismatched++;
         $display("FAIL rsp_route_0: got ro=%b wo=%b want wo=%b",
                  ro_rvalid, wo_rvalid, exp_wo_seq[0]); end
      compared++; if (l2_req !== 1'b0) begin mismatched++;
         $display("FAIL full_req_on_pop: got %b want 0", l2_req); end
      step();
      l2_rvalid = 0;
      #1;
      compared++; if ({outstanding, l2_req} !== 4'b0111) begin mismatched++;
         $display("FAIL req_return: got cnt=%0d req=%b want 3 1", outstanding, l2_req); end
      ro_req = 0; wo_req = 0;
      for (int j = 1; j < 4; j++) begin
         l2_rvalid = 1;
         #1;
         compared++;
         if ({ro_rvalid, wo_rvalid} !== {~exp_wo_seq[j], exp_wo_seq[j]}) begin mismatched++;
            $display("FAIL rsp_route_%0d: got ro=%b wo=%b want wo=%b",
                     j, ro_rvalid, wo_rvalid, exp_wo_seq[j]); end
         step();
      end
      l2_rvalid = 0;
      #1;
      compared++; if ({outstanding, err} !== 4'b0000) begin mismatched++;
         $display("FAIL full_drain: got cnt=%0d err=%b want 0 0", outstanding, err); end
   endtask

   task automatic test_lock();
      do_reset();
      wo_req = 1; wo_addr = 32'hA0; wo_wdata = 32'hCAFE; wo_be = 4'hF; l2_gnt = 0;
      #1;
      compared++; if ({l2_req, l2_wen, l2_addr} !== {2'b10, 32'hA0}) begin mismatched++;
         $display("FAIL lock_first: got req=%b wen=%b addr=%h want 1 0 a0",
                  l2_req, l2_wen, l2_addr); end
      step();
      ro_req = 1; ro_addr = 32'hB0; ro_be = 4'h1;
      for (int i = 0; i < 2; i++) begin
         #1;
         compared++;
         if ({l2_wen, l2_addr, l2_wdata, ro_gnt, wo_gnt} !== {1'b0, 32'hA0, 32'hCAFE, 2'b00})
         begin mismatched++;
            $display("FAIL lock_hold_%0d: got wen=%b addr=%h wdata=%h gnt=%b%b",
                     i, l2_wen, l2_addr, l2_wdata, ro_gnt, wo_gnt); end
         step();
      end
      l2_gnt = 1;
      #1;
      compared++; if ({ro_gnt, wo_gnt, l2_addr} !== {2'b01, 32'hA0}) begin mismatched++;
         $display("FAIL lock_grant: got ro=%b wo=%b addr=%h want 0 1 a0",
                  ro_gnt, wo_gnt, l2_addr); end
      step();
      wo_req = 0;
      #1;
      compared++; if ({ro_gnt, wo_gnt, l2_wen, l2_addr} !== {3'b101, 32'hB0}) begin mismatched++;
         $display("FAIL lock_next_ro: got ro=%b wo=%b wen=%b addr=%h want 1 0 1 b0",
                  ro_gnt, wo_gnt, l2_wen, l2_addr); end
      step();
      clear_inputs();
   endtask

   task automatic test_err();
      do_reset();
      l2_rvalid = 1; l2_rdata = 32'h77;
      #1;
      compared++; if ({ro_rvalid, wo_rvalid} !== 2'b00) begin mismatched++;
         $display("FAIL err_no_route: got ro=%b wo=%b want 0 0", ro_rvalid, wo_rvalid); end
      step();
      l2_rvalid = 0;
      #1;
      compared++; if ({err, outstanding} !== 4'b1000) begin mismatched++;
         $display("FAIL err_set: got err=%b cnt=%0d want 1 0", err, outstanding); end
      step(); step();
      compared++; if (err !== 1'b1) begin mismatched++;
         $display("FAIL err_sticky: got %b want 1", err); end
      do_reset();
      compared++; if (err !== 1'b0) begin mismatched++;
         $display("FAIL err_clear: got %b want 0", err); end
   endtask

   task automatic test_reset_mid();
      logic exp_first_wo;
`ifdef UDMA_L2_ARB_WRITE_PRIO_EN
      exp_first_wo = 1'b1;
`else
      exp_first_wo = 1'b0;
`endif
      do_reset();
      ro_req = 1; ro_addr = 32'h40; l2_gnt = 1;
      step(); step();
      compared++; if (outstanding !== 3'd2) begin mismatched++;
         $display("FAIL mid_count: got %0d want 2", outstanding); end
      rst = 1; l2_rvalid = 1;
      #1;
      compared++; if ({outstanding, l2_req, ro_gnt} !== 5'b00000) begin mismatched++;
         $display("FAIL mid_reset: got cnt=%0d req=%b gnt=%b want 0 0 0",
                  outstanding, l2_req, ro_gnt); end
      compared++; if ({ro_rvalid, wo_rvalid, err} !== 3'b000) begin mismatched++;
         $display("FAIL mid_drop: got ro=%b wo=%b err=%b want 000", ro_rvalid, wo_rvalid, err); end
      step();
      rst = 0; l2_rvalid = 0; wo_req = 1; wo_addr = 32'h80;
      #1;
      compared++;
      if ({ro_gnt, wo_gnt} !== {~exp_first_wo, exp_first_wo}) begin mismatched++;
         $display("FAIL mid_rr_restart: got ro=%b wo=%b want wo=%b",
                  ro_gnt, wo_gnt, exp_first_wo); end
      step();
      clear_inputs();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
`ifdef UDMA_L2_ARB_WRITE_PRIO_EN
      exp_wo_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
      exp_wo_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      test_reset();
      test_single_read();
      test_arbitration_and_full();
      test_lock();
      test_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000ns");
      $fatal(1);
   end

endmodule
